// File: rtl/rc4_stream_core.sv
// RC4 engine: loads a key byte-serially, runs KSA, pre-generates STREAM_LEN
// keystream bytes, then XORs a byte-serial plaintext into registered ciphertext.
module rc4_stream_core #(
  parameter int MAX_KEY_SIZE = 32,
  parameter int STREAM_LEN   = 32
) (
  input  logic       CLK_IN,
  input  logic       RESET_N_IN,
  input  logic [7:0] KEY_SIZE_IN,
  input  logic [7:0] KEY_BYTE_IN,
  input  logic [7:0] PLAIN_BYTE_IN,
  input  logic       START_IN,
  input  logic       STOP_IN,
  input  logic       HOLD_IN,
  output logic       START_KEY_CPY_OUT,
  output logic       BUSY_OUT,
  output logic       READ_PLAINTEXT_OUT,
  output logic [7:0] ENC_BYTE_OUT
);
  localparam int         KW      = (MAX_KEY_SIZE > 1) ? $clog2(MAX_KEY_SIZE) : 1;
  localparam int         SW      = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;
  localparam logic [7:0] MAX_KS  = 8'(MAX_KEY_SIZE);
  localparam logic [8:0] SL_LAST = 9'(STREAM_LEN - 1);
  localparam logic [8:0] SL_END  = 9'(STREAM_LEN);

  typedef enum logic [3:0] {
    ST_IDLE, ST_KEY_REQ, ST_KEY_LOAD, ST_INIT, ST_KSA_A, ST_KSA_B,
    ST_PRGA_1, ST_PRGA_2, ST_PRGA_3, ST_PT_REQ, ST_STREAM
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] i_q, i_d, j_q, j_d, kidx_q, kidx_d, ksz_q, ksz_d, enc_q, enc_d;

  logic [7:0] s_q   [256];
  logic [7:0] key_q [MAX_KEY_SIZE];
  logic [7:0] ks_q  [STREAM_LEN];

  logic       s_we_a, s_we_b, key_we, ks_we, mem_en;
  logic [7:0] s_wa, s_wb, s_wda, s_wdb;
  logic [7:0] s_i, s_j, j_prga, s_jp, t_idx;

  assign s_i    = s_q[i_q];
  assign s_j    = s_q[j_q];
  assign j_prga = j_q + s_i;
  assign s_jp   = s_q[j_prga];
  // After the PRGA swap the sum of the swapped pair is the output index.
  assign t_idx  = s_i + s_j;
  assign mem_en = RESET_N_IN && !STOP_IN && !HOLD_IN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    ksz_d   = ksz_q;
    enc_d   = enc_q;
    s_we_a  = 1'b0;
    s_we_b  = 1'b0;
    s_wa    = i_q;
    s_wb    = j_q;
    s_wda   = s_j;
    s_wdb   = s_i;
    key_we  = 1'b0;
    ks_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START_IN && KEY_SIZE_IN != 8'd0 && KEY_SIZE_IN <= MAX_KS) begin
          state_d = ST_KEY_REQ;
          ksz_d   = KEY_SIZE_IN;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
        end
      end
      ST_KEY_REQ: state_d = ST_KEY_LOAD;
      ST_KEY_LOAD: begin
        key_we = 1'b1;
        if (cnt_q[7:0] == ksz_q - 8'd1) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_INIT: begin
        s_we_a = 1'b1;
        s_wa   = cnt_q[7:0];
        s_wda  = cnt_q[7:0];
        if (cnt_q[7:0] == 8'hFF) begin
          state_d = ST_KSA_A;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_KSA_A: begin
        j_d     = j_q + s_i + key_q[kidx_q[KW-1:0]];
        state_d = ST_KSA_B;
      end
      ST_KSA_B: begin
        s_we_a = 1'b1;
        s_we_b = 1'b1;
        i_d    = i_q + 8'd1;
        kidx_d = (kidx_q == ksz_q - 8'd1) ? 8'd0 : kidx_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = ST_PRGA_1;
          j_d     = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_KSA_A;
        end
      end
      ST_PRGA_1: begin
        i_d     = i_q + 8'd1;
        state_d = ST_PRGA_2;
      end
      ST_PRGA_2: begin
        s_we_a  = 1'b1;
        s_we_b  = 1'b1;
        s_wb    = j_prga;
        s_wda   = s_jp;
        j_d     = j_prga;
        state_d = ST_PRGA_3;
      end
      ST_PRGA_3: begin
        ks_we = 1'b1;
        if (cnt_q == SL_LAST) begin
          state_d = ST_PT_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 9'd1;
          state_d = ST_PRGA_1;
        end
      end
      ST_PT_REQ: begin
        state_d = ST_STREAM;
        cnt_d   = '0;
      end
      // One trailing cycle keeps BUSY high while the last ciphertext byte is shown.
      ST_STREAM: begin
        if (cnt_q == SL_END) begin
          state_d = ST_IDLE;
        end else begin
          enc_d = PLAIN_BYTE_IN ^ ks_q[cnt_q[SW-1:0]];
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_N_IN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      ksz_q   <= '0;
      enc_q   <= '0;
    end else if (STOP_IN) begin
      state_q <= ST_IDLE;
    end else if (!HOLD_IN) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      ksz_q   <= ksz_d;
      enc_q   <= enc_d;
    end
  end

  // Buffers carry no reset; their contents are rebuilt on every run.
  always_ff @(posedge CLK_IN) begin
    if (mem_en) begin
      if (s_we_a) s_q[s_wa] <= s_wda;
      if (s_we_b) s_q[s_wb] <= s_wdb;
      if (key_we) key_q[cnt_q[KW-1:0]] <= KEY_BYTE_IN;
      if (ks_we)  ks_q[cnt_q[SW-1:0]] <= s_q[t_idx];
    end
  end

  assign START_KEY_CPY_OUT  = (state_q == ST_KEY_REQ);
  assign READ_PLAINTEXT_OUT = (state_q == ST_PT_REQ);
  assign BUSY_OUT           = (state_q != ST_IDLE);
  assign ENC_BYTE_OUT       = enc_q;
endmodule

// File: tb/tb_rc4_stream_core.sv
// Bench for rc4_stream_core: controller-style key/plaintext feeder checked
// against a plain RC4 reference and known-answer vectors.
module tb_rc4_stream_core;
  localparam int SL = 32;
  localparam int MK = 32;

  logic       CLK_IN = 1'b0;
  logic       RESET_N_IN, START_IN, STOP_IN, HOLD_IN;
  logic [7:0] KEY_SIZE_IN, KEY_BYTE_IN, PLAIN_BYTE_IN;
  logic       START_KEY_CPY_OUT, BUSY_OUT, READ_PLAINTEXT_OUT;
  logic [7:0] ENC_BYTE_OUT;

  rc4_stream_core #(.MAX_KEY_SIZE(MK), .STREAM_LEN(SL)) dut (
    .CLK_IN(CLK_IN), .RESET_N_IN(RESET_N_IN), .KEY_SIZE_IN(KEY_SIZE_IN),
    .KEY_BYTE_IN(KEY_BYTE_IN), .PLAIN_BYTE_IN(PLAIN_BYTE_IN), .START_IN(START_IN),
    .STOP_IN(STOP_IN), .HOLD_IN(HOLD_IN), .START_KEY_CPY_OUT(START_KEY_CPY_OUT),
    .BUSY_OUT(BUSY_OUT), .READ_PLAINTEXT_OUT(READ_PLAINTEXT_OUT),
    .ENC_BYTE_OUT(ENC_BYTE_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  int vectors = 0;
  int miscompares = 0;
  int busy_cnt = 0, kp_cnt = 0, pp_cnt = 0;
  logic [7:0] m_key [MK];
  logic [7:0] m_plain [SL];
  logic [7:0] m_ks [SL];
  logic [7:0] got [SL];
  logic [7:0] exp_q [$];

  always @(negedge CLK_IN) begin
    if (BUSY_OUT === 1'b1) busy_cnt++;
    if (START_KEY_CPY_OUT === 1'b1) kp_cnt++;
    if (READ_PLAINTEXT_OUT === 1'b1) pp_cnt++;
  end

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Textbook RC4 over integer arrays.
  task automatic model_ks(input int ksz);
    int s[256];
    int i, j, t;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + s[k] + int'(m_key[k % ksz])) % 256;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < SL; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      m_ks[n] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic run_vec(input int ksz, input int hold_n, input bit keep_start, input int rst_at);
    int cyc;
    model_ks(ksz);
    busy_cnt = 0; kp_cnt = 0; pp_cnt = 0;
    KEY_SIZE_IN = 8'(ksz);
    START_IN = 1'b1;
    tick();
    if (!keep_start) START_IN = 1'b0;
    check("key_req_pulse", {31'd0, START_KEY_CPY_OUT}, 32'd1);
    check("busy_c0", {31'd0, BUSY_OUT}, 32'd1);
    for (int n = 0; n < ksz; n++) begin
      tick();
      KEY_BYTE_IN = m_key[n];
    end
    tick();
    cyc = 0;
    while (READ_PLAINTEXT_OUT !== 1'b1 && cyc < 3000) begin
      HOLD_IN = (cyc >= 300 && cyc < 300 + hold_n);
      tick();
      cyc++;
    end
    HOLD_IN = 1'b0;
    check("pt_req_latency", 32'(cyc), 32'(256 + 512 + 3 * SL + hold_n));
    for (int n = 0; n <= SL; n++) begin
      tick();
      if (n > 0) begin
        got[n-1] = ENC_BYTE_OUT;
        check("enc_byte", {24'd0, ENC_BYTE_OUT}, {24'd0, exp_q.pop_front()});
      end
      if (n == rst_at) begin
        RESET_N_IN = 1'b0;
        tick();
        check("rst_busy", {31'd0, BUSY_OUT}, 32'd0);
        check("rst_enc", {24'd0, ENC_BYTE_OUT}, 32'd0);
        check("rst_pulses", {30'd0, START_KEY_CPY_OUT, READ_PLAINTEXT_OUT}, 32'd0);
        RESET_N_IN = 1'b1;
        exp_q.delete();
        return;
      end
      if (n < SL) begin
        PLAIN_BYTE_IN = m_plain[n];
        exp_q.push_back(m_plain[n] ^ m_ks[n]);
      end
    end
    check("busy_tail", {31'd0, BUSY_OUT}, 32'd1);
    tick();
    check("busy_end", {31'd0, BUSY_OUT}, 32'd0);
    check("enc_hold_end", {24'd0, ENC_BYTE_OUT}, {24'd0, m_plain[SL-1] ^ m_ks[SL-1]});
    check("key_pulse_count", 32'(kp_cnt), 32'd1);
    check("pt_pulse_count", 32'(pp_cnt), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(1 + ksz + 768 + 3 * SL + 1 + SL + 1 + hold_n));
    if (keep_start) begin
      tick();
      check("restart_pulse", {31'd0, START_KEY_CPY_OUT}, 32'd1);
      START_IN = 1'b0;
      STOP_IN = 1'b1;
      tick();
      STOP_IN = 1'b0;
      check("restart_stop", {31'd0, BUSY_OUT}, 32'd0);
    end
  endtask

  task automatic load_key_vec();
    logic [23:0] k;
    logic [71:0] p;
    k = 24'h4B6579;
    p = 72'h506C61696E74657874;
    for (int n = 0; n < 3; n++) m_key[n] = k[23 - 8*n -: 8];
    for (int n = 0; n < SL; n++) m_plain[n] = (n < 9) ? p[71 - 8*n -: 8] : 8'h00;
  endtask

  task automatic check_key_kat(input string tag);
    logic [71:0] kat;
    kat = 72'hBBF316E8D940AF0AD3;
    for (int n = 0; n < 9; n++) check(tag, {24'd0, got[n]}, {24'd0, kat[71 - 8*n -: 8]});
  endtask

  initial begin
    logic [255:0] k1, p1;
    RESET_N_IN = 1'b0; START_IN = 1'b0; STOP_IN = 1'b0; HOLD_IN = 1'b0;
    KEY_SIZE_IN = 8'd0; KEY_BYTE_IN = 8'd0; PLAIN_BYTE_IN = 8'd0;
    repeat (3) tick();
    check("reset_busy", {31'd0, BUSY_OUT}, 32'd0);
    check("reset_key_req", {31'd0, START_KEY_CPY_OUT}, 32'd0);
    check("reset_pt_req", {31'd0, READ_PLAINTEXT_OUT}, 32'd0);
    check("reset_enc", {24'd0, ENC_BYTE_OUT}, 32'd0);
    RESET_N_IN = 1'b1;
    tick();

    // 32-byte key vector, last byte known, then frozen under HOLD.
    k1 = 256'hae6c3c41884d35df3ab5adf30f5b2d360938c658341886b0ba510b421e5ab405;
    p1 = 256'h3ae280d0d5cd70d8e0f81300dc9031a2e0f8512cb35a7579fd79575cf287c595;
    for (int n = 0; n < 32; n++) begin
      m_key[n] = k1[255 - 8*n -: 8];
      m_plain[n] = p1[255 - 8*n -: 8];
    end
    run_vec(32, 0, 1'b0, -1);
    check("kat32_last", {24'd0, got[SL-1]}, 32'h79);
    HOLD_IN = 1'b1;
    repeat (5) tick();
    check("hold_enc", {24'd0, ENC_BYTE_OUT}, 32'h79);
    check("hold_busy", {31'd0, BUSY_OUT}, 32'd0);
    HOLD_IN = 1'b0;
    tick();

    load_key_vec();
    run_vec(3, 0, 1'b0, -1);
    check_key_kat("kat_key");

    // Illegal key sizes must be ignored.
    for (int t = 0; t < 2; t++) begin
      busy_cnt = 0; kp_cnt = 0;
      KEY_SIZE_IN = (t == 0) ? 8'd0 : 8'd33;
      START_IN = 1'b1;
      repeat (4) tick();
      START_IN = 1'b0;
      tick();
      check("bad_size_busy", 32'(busy_cnt), 32'd0);
      check("bad_size_pulse", 32'(kp_cnt), 32'd0);
    end

    // STOP in the middle of the key schedule, then a clean re-run.
    KEY_SIZE_IN = 8'd3;
    START_IN = 1'b1;
    tick();
    START_IN = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      KEY_BYTE_IN = m_key[n];
    end
    repeat (400) tick();
    STOP_IN = 1'b1;
    tick();
    STOP_IN = 1'b0;
    check("stop_busy", {31'd0, BUSY_OUT}, 32'd0);
    run_vec(3, 0, 1'b0, -1);
    check_key_kat("kat_after_stop");

    // Reset pulse mid-stream, then a clean re-run.
    run_vec(3, 0, 1'b0, 10);
    tick();
    run_vec(3, 0, 1'b0, -1);
    check_key_kat("kat_after_reset");

    // START level-held across a whole run.
    run_vec(3, 0, 1'b1, -1);
    tick();

    // Random keys and plaintexts, with HOLD inserted during the key schedule.
    for (int r = 0; r < 6; r++) begin
      int ksz;
      ksz = (r == 0) ? 1 : (r == 1) ? MK : int'($urandom_range(1, MK));
      for (int n = 0; n < MK; n++) m_key[n] = 8'($urandom_range(0, 255));
      for (int n = 0; n < SL; n++) m_plain[n] = 8'($urandom_range(0, 255));
      run_vec(ksz, int'($urandom_range(0, 6)), 1'b0, -1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
